harmonic_accumulator: RTL

Consumer end of the sample-position handshake. For each output sample it walks harmonics 0..N-1 and takes each phase position. It looks up the sine LUT, scales each harmonic by a geometrically decaying amplitude, and sums the results. It then emits one saturated 16-bit additive-synthesis sample to the DAC/I2S path. It drives the harmonic index and the next_sample acknowledge back to the position generator.

---
 rtl/harmonic_accumulator_pkg.sv | 40 ++++
 rtl/harmonic_accumulator_mac.sv | 53 +++++
 rtl/harmonic_accumulator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/harmonic_accumulator_pkg.sv
// harmonic_accumulator_pkg: shared types, constants and helpers for the
// additive-synthesis harmonic accumulator.
//   state_e           FSM state encoding
//   LUT_ADDR_W        sine LUT address width
//   POS_TO_LUT_SHIFT  phase position to LUT address right shift
//   AMP_ONE           initial (unity) harmonic amplitude, Q1.15
//   saturate16()      clip a signed 32-bit value into signed 16-bit range
package harmonic_accumulator_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_POS = 3'd1,
        LUT      = 3'd2,
        MAC      = 3'd3,
        ACK      = 3'd4,
        OUTPUT   = 3'd5
    } state_e;

    localparam int unsigned LUT_ADDR_W       = 11;
    localparam int unsigned POS_TO_LUT_SHIFT = 5;
    localparam int unsigned SAMPLE_W         = 16;
    localparam logic [15:0] AMP_ONE          = 16'h7FFF;

    localparam logic signed [31:0] SAT_MAX = 32'sd32767;
    localparam logic signed [31:0] SAT_MIN = -32'sd32768;

    // Clip to the signed 16-bit range.
    function automatic logic [15:0] saturate16(input logic signed [31:0] x);
        logic [15:0] r;
        if (x > SAT_MAX) begin
            r = 16'h7FFF;
        end else if (x < SAT_MIN) begin
            r = 16'h8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/harmonic_accumulator_mac.sv
// harmonic_mac: per-harmonic multiply-accumulate with geometric amplitude decay.
//   clock, reset_n  clock and synchronous active-low reset
//   clear           start of a new output sample: zero acc, unity amplitude, latch decay
//   mac_en          accumulate lut_data * amplitude and decay the amplitude
//   decay           unsigned Q1.15 per-harmonic multiplier (sampled on clear)
//   lut_data        signed sine sample
//   acc             signed running sum (registered)
//   amplitude       current harmonic amplitude, Q1.15 (registered)
module harmonic_mac
    import harmonic_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W = 24
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    mac_en,
    input  logic [15:0]             decay,
    input  logic [15:0]             lut_data,
    output logic signed [ACC_W-1:0] acc,
    output logic [15:0]             amplitude
);

    logic [15:0]             decay_q;
    logic signed [32:0]      product;
    logic signed [ACC_W-1:0] term;
    logic [31:0]             amp_product;
    logic [15:0]             amp_next;

    // Amplitude is non-negative, so zero-extend it before the signed multiply.
    always_comb begin
        product     = 33'(signed'(lut_data)) * 33'(signed'({1'b0, amplitude}));
        term        = ACC_W'(product >>> 15);
        amp_product = 32'(amplitude) * 32'(decay_q);
        amp_next    = 16'(amp_product >> 15);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc       <= '0;
            amplitude <= AMP_ONE;
            decay_q   <= '0;
        end else if (clear) begin
            acc       <= '0;
            amplitude <= AMP_ONE;
            decay_q   <= decay;
        end else if (mac_en) begin
            acc       <= acc + term;
            amplitude <= amp_next;
        end
    end

endmodule

// File: rtl/harmonic_accumulator.sv
// harmonic_accumulator: consumes per-harmonic phase positions, looks up the
// sine LUT, scales each harmonic by a decaying amplitude and emits one
// saturated 16-bit additive-synthesis sample per sample_tick.
//   clock, reset_n        clock and synchronous active-low reset
//   sample_tick           start building a new output sample (ignored when busy)
//   harmonic_count        harmonics to sum (0 -> 1, clamped to NUM_HARMONICS)
//   decay                 Q1.15 per-harmonic amplitude multiplier
//   sample_ready          position generator has a valid sample_position
//   sample_position       phase of the current harmonic
//   next_sample           one-cycle acknowledge: position consumed
//   harmonic              current harmonic index
//   lut_addr, lut_data    synchronous sine ROM interface (1-cycle latency)
//   sample_out            saturated signed output sample
//   sample_valid          one-cycle pulse when sample_out updates
// Optional (HARMONIC_OVERRUN_EN): overrun sticky flag and saturating
// overrun_count for sample_tick arriving outside IDLE; cleared by reset only.
module harmonic_accumulator
    import harmonic_accumulator_pkg::*;
#(
    parameter int unsigned NUM_HARMONICS = 64,
    parameter int unsigned ACC_W         = 24,
    parameter int unsigned OUT_SHIFT     = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sample_tick,
    input  logic [7:0]            harmonic_count,
    input  logic [15:0]           decay,
    input  logic                  sample_ready,
    input  logic [15:0]           sample_position,
    output logic                  next_sample,
    output logic [7:0]            harmonic,
    output logic [LUT_ADDR_W-1:0] lut_addr,
    input  logic [15:0]           lut_data,
    output logic [15:0]           sample_out,
    output logic                  sample_valid
`ifdef HARMONIC_OVERRUN_EN
    ,
    output logic                  overrun,
    output logic [7:0]            overrun_count
`endif
);

    state_e state;
    state_e state_next;

    logic                    start_c;
    logic                    capture_c;
    logic                    mac_en_c;
    logic                    ack_c;
    logic                    emit_c;
    logic [8:0]              count_clamped_c;
    logic [7:0]              last_next_c;
    logic [7:0]              last;
    logic signed [ACC_W-1:0] acc;
    logic [15:0]             amplitude;
    logic                    unused_pos_bits;

    // Sub-LUT phase bits are intentionally discarded.
    assign unused_pos_bits = ^{sample_position[POS_TO_LUT_SHIFT-1:0], amplitude};

    // Effective last harmonic index for the sample about to start.
    always_comb begin
        count_clamped_c = (harmonic_count == 8'd0) ? 9'd1 : 9'(harmonic_count);
        if (count_clamped_c > 9'(NUM_HARMONICS)) begin
            count_clamped_c = 9'(NUM_HARMONICS);
        end
        last_next_c = 8'(count_clamped_c - 9'd1);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        capture_c  = 1'b0;
        mac_en_c   = 1'b0;
        ack_c      = 1'b0;
        emit_c     = 1'b0;
        case (state)
            IDLE: begin
                if (sample_tick) begin
                    start_c    = 1'b1;
                    state_next = WAIT_POS;
                end
            end
            WAIT_POS: begin
                if (sample_ready) begin
                    capture_c  = 1'b1;
                    state_next = LUT;
                end
            end
            LUT: begin
                state_next = MAC;
            end
            MAC: begin
                mac_en_c   = 1'b1;
                state_next = ACK;
            end
            ACK: begin
                ack_c      = 1'b1;
                state_next = (harmonic == last) ? OUTPUT : WAIT_POS;
            end
            OUTPUT: begin
                emit_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered handshake, address and result outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            next_sample  <= 1'b0;
            sample_valid <= 1'b0;
            harmonic     <= '0;
            lut_addr     <= '0;
            sample_out   <= '0;
            last         <= '0;
        end else begin
            next_sample  <= ack_c;
            sample_valid <= emit_c;
            if (start_c) begin
                last <= last_next_c;
            end
            if (capture_c) begin
                lut_addr <= sample_position[15:POS_TO_LUT_SHIFT];
            end
            // Index advances with the acknowledge so the generator sees both together.
            if (ack_c) begin
                harmonic <= (harmonic == last) ? 8'd0 : harmonic + 8'd1;
            end
            if (emit_c) begin
                sample_out <= saturate16(32'(acc >>> OUT_SHIFT));
            end
        end
    end

    harmonic_mac #(
        .ACC_W(ACC_W)
    ) u_mac (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (start_c),
        .mac_en   (mac_en_c),
        .decay    (decay),
        .lut_data (lut_data),
        .acc      (acc),
        .amplitude(amplitude)
    );

`ifdef HARMONIC_OVERRUN_EN
    // Ticks arriving while a sample is in progress are counted, not queued.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else if (sample_tick && (state != IDLE)) begin
            overrun <= 1'b1;
            if (overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end
`endif

endmodule
